// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: multi-cycle load/store unit of the NPC core.
//
// Accepts one EXU access at a time (req_valid/req_ready). Then drives a word-wide memory bus
// (mem_req held until mem_ack) and returns one resp_valid pulse. For loads the response
// carries aligned, extended data. If mem_ack never comes, the access is aborted after
// TIMEOUT cycles and the response carries resp_err.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/req_ready      EXU handshake; ready only while idle
//   req_wen/size/signed      access kind (size: 0 byte, 1 half, 2 word, 3 reserved)
//   req_addr/req_wdata       effective address, right-aligned store data
//   resp_valid/rdata/err     one-cycle completion pulse with load data / error flag
//   mem_req/we/addr          bus request (word address), held until mem_ack
//   mem_wdata/wmask          store data replicated into byte lanes, byte enables
//   mem_ack/mem_rdata        bus completion and read word
//
// Optional feature: define YSYX_25020047_LSU_ALIGN_CHECK_EN to reject misaligned half/word
// accesses and size 3 without touching the bus. The error response follows one cycle after
// accept.

module ysyx_25020047_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   localparam logic [9:0] TmoLast = 10'(TIMEOUT - 1);

   state_e     state_q;
   logic [9:0] tmo_cnt_q;
   logic       wen_q;
   logic       signed_q;
   logic [1:0] size_q;
   logic [1:0] off_q;

   // Lane placement of the incoming store; size 3 falls through to word.
   logic [3:0]  wmask_in;
   logic [31:0] wdata_in;
   always_comb begin
      wmask_in = 4'b1111;
      wdata_in = req_wdata;
      case (req_size)
         2'd0: begin
            wmask_in = 4'b0001 << req_addr[1:0];
            wdata_in = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            wmask_in = 4'b0011 << {req_addr[1], 1'b0};
            wdata_in = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
   logic misaligned;
   always_comb begin
      misaligned = (req_size == 2'd3) ||
                   ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
   end
`endif

   // Load alignment and extension from the latched request.
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (off_q)
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         2'd3:    ld_byte = mem_rdata[31:24];
         default: ld_byte = mem_rdata[7:0];
      endcase
      ld_half   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_data = mem_rdata;
      case (size_q)
         2'd0:    load_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
         2'd1:    load_data = {{16{signed_q & ld_half[15]}}, ld_half};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         tmo_cnt_q  <= '0;
         wen_q      <= 1'b0;
         signed_q   <= 1'b0;
         size_q     <= 2'd0;
         off_q      <= 2'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
      end else begin
         resp_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  wen_q     <= req_wen;
                  signed_q  <= req_signed;
                  size_q    <= req_size;
                  off_q     <= req_addr[1:0];
                  tmo_cnt_q <= '0;
                  req_ready <= 1'b0;
                  mem_addr  <= {req_addr[31:2], 2'b00};
`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
                  if (misaligned) begin
                     state_q    <= StResp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
`else
                  begin
`endif
                     state_q   <= StBusy;
                     mem_req   <= 1'b1;
                     mem_we    <= req_wen;
                     mem_wmask <= req_wen ? wmask_in : 4'b0000;
                     mem_wdata <= req_wen ? wdata_in : 32'h0;
                  end
               end
            end
            StBusy: begin
               if (mem_ack) begin
                  state_q    <= StResp;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_wmask  <= '0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= wen_q ? 32'h0 : load_data;
               end else if (tmo_cnt_q == TmoLast) begin
                  // Ack in this same cycle would have won above.
                  state_q    <= StResp;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_wmask  <= '0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 10'd1;
               end
            end
            StResp: begin
               state_q   <= StIdle;
               req_ready <= 1'b1;
            end
            default: begin
               state_q   <= StIdle;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for ysyx_25020047_lsu: stimulus pushes expected bus transactions and
// responses into queues, a memory responder and a response monitor pop and compare.

module tb_ysyx_25020047_lsu;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   ysyx_25020047_lsu #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic        we;
      int          delay;      // cycles of mem_req before ack; -1 = never ack
      int          hi;         // expected number of cycles mem_req stays high
      int          start_cyc;
      logic [31:0] rdata;
   } mem_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } resp_exp_t;

   mem_exp_t  mem_q[$];
   resp_exp_t resp_q[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one access, computing the expected bus transaction and response from the rules.
   task automatic issue(input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay, input bit want_resp,
                        input int hi_ovr);
      int guard = 0;
      int nb, start, acc, m;
      bit err;
      logic [31:0] mask, ld, w;
      mem_exp_t  me;
      resp_exp_t re;
      @(negedge clk);
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         check("req_ready_wait", {31'b0, req_ready}, 32'h1);
         return;
      end
      req_valid  = 1'b1;
      req_wen    = wen;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      acc = cyc;

      nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      start = (nb == 4) ? 0 : ((int'(addr % 4) / nb) * nb);
      err   = 1'b0;
`ifdef YSYX_25020047_LSU_ALIGN_CHECK_EN
      err = (size == 2'd3) || ((addr % nb) != 0);
`endif
      m = ((1 << nb) - 1) << start;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
      ld = (rdata >> (8 * start)) & mask;
      if (sgn && nb < 4 && ld[8*nb-1]) ld = ld | ~mask;

      if (err) begin
         re.rdata = '0;
         re.err   = 1'b1;
         re.cyc   = acc + 1;
      end else begin
         me.addr      = addr & 32'hFFFF_FFFC;
         me.we        = wen;
         me.wmask     = wen ? m[3:0] : 4'b0000;
         me.wdata     = wen ? w : 32'h0;
         me.delay     = delay;
         me.start_cyc = acc + 1;
         me.rdata     = rdata;
         if (delay < 0) begin
            me.hi    = TMO;
            re.rdata = '0;
            re.err   = 1'b1;
            re.cyc   = acc + TMO + 1;
         end else begin
            me.hi    = delay + 1;
            re.rdata = wen ? 32'h0 : ld;
            re.err   = 1'b0;
            re.cyc   = acc + delay + 2;
         end
         if (hi_ovr > 0) me.hi = hi_ovr;
         mem_q.push_back(me);
      end
      if (want_resp) resp_q.push_back(re);

      // Keep req_valid high with junk one more cycle: the LSU is busy and must ignore it.
      @(negedge clk);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wen   = 1'($urandom);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Memory responder: checks each bus request against the scoreboard and acks it.
   initial begin : responder
      mem_exp_t cur;
      bit serving = 1'b0;
      int hi = 0;
      forever begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (mem_req) begin
            if (!serving) begin
               if (mem_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_mem_req: got mem_req=1, expected 0 (cycle %0d)", cyc);
                  cur.delay = 0;
                  cur.hi    = 1;
                  cur.rdata = '0;
               end else begin
                  cur = mem_q.pop_front();
                  check("mem_req_start", cyc, cur.start_cyc);
                  check("mem_addr", mem_addr, cur.addr);
                  check("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
                  check("mem_wmask", {28'b0, mem_wmask}, {28'b0, cur.wmask});
                  if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
               end
               serving = 1'b1;
               hi = 0;
            end
            hi++;
            if (cur.delay >= 0 && hi == cur.delay + 1) begin
               mem_ack   = 1'b1;
               mem_rdata = cur.rdata;
            end
         end else begin
            if (serving) begin
               check("mem_req_cycles", hi, cur.hi);
               serving = 1'b0;
            end
            // Stray acks while no request is pending must be ignored.
            mem_ack = ($urandom_range(0, 1) == 1);
         end
      end
   end

   // Response monitor.
   initial begin : monitor
      resp_exp_t e;
      forever begin
         @(negedge clk);
         if (resp_valid) begin
            if (resp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp: got resp_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
               e = resp_q.pop_front();
               check("resp_cycle", cyc, e.cyc);
               check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
               check("resp_rdata", resp_rdata, e.rdata);
            end
         end
      end
   end

   initial begin : stimulus
      int g;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      check("rst_resp_err", {31'b0, resp_err}, 32'h0);
      check("rst_mem_req", {31'b0, mem_req}, 32'h0);
      check("rst_mem_we", {31'b0, mem_we}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_wmask", {28'b0, mem_wmask}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);

      // Directed cases.
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 0);
      issue(1'b0, 2'd0, 1'b0, 32'h8000_0013, 32'h0, 32'h80AB_CDEF, 1, 1'b1, 0);
      issue(1'b0, 2'd0, 1'b1, 32'h8000_0013, 32'h0, 32'h80AB_CDEF, 2, 1'b1, 0);
      issue(1'b1, 2'd1, 1'b0, 32'h8000_0102, 32'h1234_5678, 32'h0, 0, 1'b1, 0);
      issue(1'b1, 2'd0, 1'b0, 32'h8000_0101, 32'h1234_5678, 32'h0, 1, 1'b1, 0);
      issue(1'b0, 2'd1, 1'b1, 32'h8000_0202, 32'h0, 32'h8001_7FFF, 0, 1'b1, 0);
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 32'h1111_2222, -1, 1'b1, 0);
      issue(1'b0, 2'd2, 1'b0, 32'h8000_000C, 32'h0, 32'h3333_4444, TMO - 1, 1'b1, 0);
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 32'h5555_6666, 0, 1'b1, 0);
      issue(1'b1, 2'd3, 1'b0, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1, 1'b1, 0);

      // Reset while BUSY: request held 2 cycles, then abandoned with no response.
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 32'h0, -1, 1'b0, 2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("busy_rst_mem_req", {31'b0, mem_req}, 32'h0);
      @(negedge clk);
      check("busy_rst_req_ready", {31'b0, req_ready}, 32'h1);
      repeat (3) @(negedge clk);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         int d;
         d = int'($urandom_range(0, TMO));
         if (d == int'(TMO)) d = -1;
         issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
               32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom, d, 1'b1, 0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      g = 0;
      while ((resp_q.size() != 0 || mem_q.size() != 0) && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("drain_resp_q", resp_q.size(), 32'h0);
      check("drain_mem_q", mem_q.size(), 32'h0);
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
